gmii_rx_deframer: RTL



---
 rtl/eth_pkg.sv | 19 +
 rtl/gmii_rx_deframer_if.sv | 13 +
 rtl/crc32_byte.sv | 19 +
 rtl/gmii_rx_deframer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the RX deframer state type.
// Also used by the TX FCS inserter.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hDEBB20E3;
    localparam int          ETH_FCS_LEN       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } deframer_state_e;

endpackage

// File: rtl/gmii_rx_deframer_if.sv
// Byte-wide AXI-Stream bundle carrying deframed payload.
// tuser flags a bad frame on the tlast beat.
interface gmii_rx_deframer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);

endinterface

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Shared with the TX FCS inserter.
module crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ ETH_CRC_POLY)
                                   : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII RX deframer: strips preamble/SFD, checks and removes FCS, emits AXI-Stream.
// Define GMII_RX_DEFRAMER_STATS_EN to add good/bad/dropped frame counters.
module gmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MAX_PREAMBLE  = 7
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_gmii_rxd,
    input  logic               i_gmii_rx_dv,
    input  logic               i_gmii_rx_er,
    gmii_rx_deframer_if.master m_axis
`ifdef GMII_RX_DEFRAMER_STATS_EN
    ,
    output logic [31:0]        o_good_frames,
    output logic [31:0]        o_bad_frames,
    output logic [31:0]        o_dropped_frames
`endif
);

    localparam int DL_DEPTH = ETH_FCS_LEN + 1;
    localparam int LW       = $clog2(MAX_FRAME_LEN + 2);
    localparam int PW       = $clog2(MAX_PREAMBLE + 1);

    localparam logic [LW-1:0] LEN_MIN = LW'(MIN_FRAME_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_FRAME_LEN);
    localparam logic [LW-1:0] LEN_SAT = LW'(MAX_FRAME_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(MAX_PREAMBLE);
    localparam logic [2:0]    DL_FULL = 3'(DL_DEPTH);

    deframer_state_e state, state_nxt;

    logic [DL_DEPTH-1:0][7:0] dl;
    logic [2:0]               fill;
    logic [LW-1:0]            len;
    logic [PW-1:0]            pre_cnt;
    logic [31:0]              crc, crc_next;
    logic                     er_seen;
    // Cleared by reset, set by any dv=0 cycle: never lock on mid-frame.
    logic                     armed;

    logic push, emit, fin, last_beat, bad, sfd_hit, drop_entry, vanish;

    crc32_byte u_crc (
        .crc      (crc),
        .data     (i_gmii_rxd),
        .crc_next (crc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_gmii_rx_dv) begin
                    state_nxt = (armed && i_gmii_rxd == ETH_PREAMBLE_BYTE)
                              ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!i_gmii_rx_dv || i_gmii_rx_er)
                    state_nxt = ST_DROP;
                else if (i_gmii_rxd == ETH_SFD)
                    state_nxt = ST_PAYLOAD;
                else if (i_gmii_rxd != ETH_PREAMBLE_BYTE || pre_cnt == PRE_MAX)
                    state_nxt = ST_DROP;
            end
            ST_PAYLOAD: if (!i_gmii_rx_dv) state_nxt = ST_IDLE;
            ST_DROP:    if (!i_gmii_rx_dv) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push       = (state == ST_PAYLOAD) && i_gmii_rx_dv;
        fin        = (state == ST_PAYLOAD) && !i_gmii_rx_dv;
        emit       = push && (fill == DL_FULL);
        last_beat  = fin && (fill == DL_FULL);
        vanish     = fin && (fill != DL_FULL);
        sfd_hit    = (state == ST_PREAMBLE) && (state_nxt == ST_PAYLOAD);
        drop_entry = (state != ST_DROP) && (state_nxt == ST_DROP);
        bad        = (crc != ETH_CRC_RESIDUE) || er_seen || i_gmii_rx_er
                  || (len < LEN_MIN) || (len > LEN_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
            dl            <= '0;
            fill          <= '0;
            len           <= '0;
            pre_cnt       <= '0;
            crc           <= ETH_CRC_INIT;
            er_seen       <= 1'b0;
            armed         <= 1'b0;
        end else begin
            m_axis.tvalid <= emit || last_beat;
            m_axis.tlast  <= last_beat;
            m_axis.tuser  <= last_beat && bad;
            if (emit || last_beat) m_axis.tdata <= dl[DL_DEPTH-1];
            if (!i_gmii_rx_dv) armed <= 1'b1;

            if (state == ST_IDLE)
                pre_cnt <= PW'(1);
            else if (state == ST_PREAMBLE && i_gmii_rxd == ETH_PREAMBLE_BYTE)
                pre_cnt <= pre_cnt + PW'(1);

            if (sfd_hit) begin
                crc     <= ETH_CRC_INIT;
                fill    <= '0;
                len     <= '0;
                er_seen <= 1'b0;
            end else if (push) begin
                crc <= crc_next;
                dl  <= {dl[DL_DEPTH-2:0], i_gmii_rxd};
                if (fill != DL_FULL) fill <= fill + 3'd1;
                if (len != LEN_SAT)  len  <= len + LW'(1);
                if (i_gmii_rx_er)    er_seen <= 1'b1;
            end else if (fin) begin
                fill <= '0;
            end
        end
    end

`ifdef GMII_RX_DEFRAMER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_good_frames    <= '0;
            o_bad_frames     <= '0;
            o_dropped_frames <= '0;
        end else begin
            if (last_beat && !bad)      o_good_frames    <= o_good_frames + 32'd1;
            if (last_beat && bad)       o_bad_frames     <= o_bad_frames + 32'd1;
            if (drop_entry || vanish)   o_dropped_frames <= o_dropped_frames + 32'd1;
        end
    end
`endif

endmodule
